// File: rtl/cpu8_program_loader.sv
// cpu8_program_loader: framed byte-stream loader driving cpu8 service-mode memory ports; LOADER_CHECKSUM_EN adds a trailing checksum byte
module cpu8_program_loader #(
    parameter logic [7:0] CMD_PROG       = 8'hA0,
    parameter logic [7:0] CMD_DATA       = 8'hA1,
    parameter int         RELEASE_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_in_data,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic       o_service_mode,
    output logic       o_cpu_rst,
    output logic [7:0] o_program_memory_address,
    output logic [7:0] o_program_memory_data_in,
    output logic       o_program_memory_write_enable,
    output logic [7:0] o_data_memory_address,
    output logic [7:0] o_data_memory_data_in,
    output logic       o_data_memory_write_enable,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);
    localparam logic [7:0] RC = 8'(RELEASE_CYCLES);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_PAYLOAD,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_RELEASE
    } state_t;
    state_t     r_state, w_next;
    logic       w_acc, w_is_cmd;
    logic       r_sel_data, r_error, r_done, r_we;
    logic [7:0] r_base, r_idx, r_rel, r_addr, r_data;
    logic [8:0] r_rem;
    assign w_acc    = i_in_valid & (r_state != S_RELEASE);
    assign w_is_cmd = (i_in_data == CMD_PROG) || (i_in_data == CMD_DATA);
    assign o_done   = r_done;
    assign o_error  = r_error;
    assign o_program_memory_write_enable = r_we & ~r_sel_data;
    assign o_program_memory_address      = r_sel_data ? 8'h00 : r_addr;
    assign o_program_memory_data_in      = r_sel_data ? 8'h00 : r_data;
    assign o_data_memory_write_enable    = r_we & r_sel_data;
    assign o_data_memory_address         = r_sel_data ? r_addr : 8'h00;
    assign o_data_memory_data_in         = r_sel_data ? r_data : 8'h00;
    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end
    // next state and core-control outputs; service_mode covers only the first release cycle (the final write)
    always_comb begin
        w_next         = r_state;
        o_in_ready     = (r_state != S_RELEASE);
        o_busy         = (r_state != S_IDLE);
        o_cpu_rst      = (r_state != S_IDLE);
        o_service_mode = (r_state != S_IDLE) && ((r_state != S_RELEASE) || (r_rel == 8'd0));
        case (r_state)
            S_IDLE:    if (w_acc && w_is_cmd) w_next = S_ADDR;
            S_ADDR:    if (w_acc) w_next = S_COUNT;
            S_COUNT:   if (w_acc) w_next = S_PAYLOAD;
`ifdef LOADER_CHECKSUM_EN
            S_PAYLOAD: if (w_acc && r_rem == 9'd1) w_next = S_CHECK;
            S_CHECK:   if (w_acc) w_next = S_RELEASE;
`else
            S_PAYLOAD: if (w_acc && r_rem == 9'd1) w_next = S_RELEASE;
`endif
            S_RELEASE: if (r_rel == RC) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    // running 8-bit sum of every frame byte, restarted by each byte taken in IDLE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_sum <= 8'h00;
        else if (w_acc) r_sum <= (r_state == S_IDLE) ? i_in_data : r_sum + i_in_data;
    end
`endif
    // frame latches, one-cycle write strobe, release timer, done and sticky error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel_data <= 1'b0;
            r_error    <= 1'b0;
            r_done     <= 1'b0;
            r_we       <= 1'b0;
            r_base     <= 8'h00;
            r_idx      <= 8'h00;
            r_rel      <= 8'h00;
            r_addr     <= 8'h00;
            r_data     <= 8'h00;
            r_rem      <= 9'd0;
        end else begin
            r_we   <= 1'b0;
            r_addr <= 8'h00;
            r_data <= 8'h00;
            r_done <= (r_state == S_RELEASE) && (r_rel == RC) && !r_error;
            r_rel  <= (r_state == S_RELEASE) ? r_rel + 8'd1 : 8'd0;
            if (w_acc) begin
                case (r_state)
                    S_IDLE: begin
                        r_error <= ~w_is_cmd;
                        if (w_is_cmd) r_sel_data <= (i_in_data == CMD_DATA);
                    end
                    S_ADDR:  r_base <= i_in_data;
                    S_COUNT: begin
                        r_rem <= {i_in_data == 8'h00, i_in_data};
                        r_idx <= 8'h00;
                    end
                    S_PAYLOAD: begin
                        r_we   <= 1'b1;
                        r_addr <= r_base + r_idx;
                        r_data <= i_in_data;
                        r_idx  <= r_idx + 8'd1;
                        r_rem  <= r_rem - 9'd1;
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHECK: if (r_sum + i_in_data != 8'h00) r_error <= 1'b1;
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cpu8_program_loader.sv
// tb_cpu8_program_loader: directed and randomized frames checked against a frame-level model of writes and release timing
module tb_cpu8_program_loader;
    localparam int RC = 2;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] i_in_data = 8'h00;
    logic       i_in_valid = 1'b0;
    logic       o_in_ready, o_service_mode, o_cpu_rst, o_busy, o_done, o_error;
    logic [7:0] o_program_memory_address, o_program_memory_data_in;
    logic [7:0] o_data_memory_address, o_data_memory_data_in;
    logic       o_program_memory_write_enable, o_data_memory_write_enable;
    int         checks = 0, failures = 0, cyc = 0;
    logic [7:0] pl[$];
    logic [63:0] obs_wr[$];
    int         sm_rise[$], sm_fall[$], rst_rise[$], rst_fall[$], done_q[$];
    logic       p_sm = 1'b0, p_rst = 1'b0;
    logic [39:0] w_outs;

    cpu8_program_loader dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_in_data(i_in_data), .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready), .o_service_mode(o_service_mode), .o_cpu_rst(o_cpu_rst),
        .o_program_memory_address(o_program_memory_address),
        .o_program_memory_data_in(o_program_memory_data_in),
        .o_program_memory_write_enable(o_program_memory_write_enable),
        .o_data_memory_address(o_data_memory_address),
        .o_data_memory_data_in(o_data_memory_data_in),
        .o_data_memory_write_enable(o_data_memory_write_enable),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    assign w_outs = {o_in_ready, o_service_mode, o_cpu_rst,
                     o_program_memory_write_enable, o_program_memory_address, o_program_memory_data_in,
                     o_data_memory_write_enable, o_data_memory_address, o_data_memory_data_in,
                     o_busy, o_done, o_error};

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // per-cycle observation of write pulses and control edges
    always @(negedge i_clk) begin
        chk("dual_we", {63'b0, o_program_memory_write_enable & o_data_memory_write_enable}, 64'd0);
        chk("idle_port_zero", {32'b0,
            o_program_memory_write_enable ? 16'h0 : {o_program_memory_address, o_program_memory_data_in},
            o_data_memory_write_enable    ? 16'h0 : {o_data_memory_address, o_data_memory_data_in}}, 64'd0);
        if (o_program_memory_write_enable)
            obs_wr.push_back({15'b0, 1'b0, o_program_memory_address, o_program_memory_data_in, 32'(cyc)});
        if (o_data_memory_write_enable)
            obs_wr.push_back({15'b0, 1'b1, o_data_memory_address, o_data_memory_data_in, 32'(cyc)});
        if (o_service_mode && !p_sm) sm_rise.push_back(cyc);
        if (!o_service_mode && p_sm) sm_fall.push_back(cyc);
        if (o_cpu_rst && !p_rst) rst_rise.push_back(cyc);
        if (!o_cpu_rst && p_rst) rst_fall.push_back(cyc);
        if (o_done) done_q.push_back(cyc);
        p_sm  = o_service_mode;
        p_rst = o_cpu_rst;
    end

    task automatic clear_obs();
        obs_wr.delete(); sm_rise.delete(); sm_fall.delete();
        rst_rise.delete(); rst_fall.delete(); done_q.delete();
    endtask

    task automatic send(input logic [7:0] b, output int ac);
        int n = 0;
        i_in_data  = b;
        i_in_valid = 1'b1;
        while (!o_in_ready && n < 20) begin
            @(negedge i_clk); #1;
            n++;
        end
        chk("ready_wait", {63'b0, n < 20}, 64'd1);
        @(posedge i_clk); #1;
        ac = cyc;
        @(negedge i_clk); #1;
        i_in_valid = 1'b0;
        i_in_data  = 8'($urandom);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input int gap, input bit bad_ck);
        logic [63:0] exp_wr[$];
        logic [7:0]  cnt, sum;
        logic        sel;
        int          c0, k, a;
        clear_obs();
        sel = (cmd == 8'hA1);
        cnt = 8'(pl.size());
        sum = cmd + addr + cnt;
        send(cmd, c0);
        send(addr, a);
        send(cnt, a);
        k = a;
        foreach (pl[i]) begin
            if ((gap == 1 && i % 2 == 1) || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                i_in_valid = 1'b0;
                i_in_data  = 8'($urandom);
                @(negedge i_clk); #1;
            end
            send(pl[i], k);
            exp_wr.push_back({15'b0, sel, 8'(addr + 8'(i)), pl[i], 32'(k)});
            sum += pl[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send(8'(8'h00 - sum) + (bad_ck ? 8'h01 : 8'h00), k);
`endif
        repeat (RC + 3) begin
            @(negedge i_clk); #1;
        end
        chk("wr_count", obs_wr.size(), exp_wr.size());
        foreach (exp_wr[i]) if (i < obs_wr.size()) chk("wr", obs_wr[i], exp_wr[i]);
        chk("sm_rise", sm_rise.size() == 1 ? sm_rise[0] : -1, c0);
        chk("sm_fall", sm_fall.size() == 1 ? sm_fall[0] : -1, k + 1);
        chk("rst_rise", rst_rise.size() == 1 ? rst_rise[0] : -1, c0);
        chk("rst_fall", rst_fall.size() == 1 ? rst_fall[0] : -1, k + 1 + RC);
        chk("done_cnt", done_q.size(), bad_ck ? 0 : 1);
        if (!bad_ck && done_q.size() == 1) chk("done_cyc", done_q[0], k + 1 + RC);
        chk("end_state", {59'b0, o_busy, o_error, o_service_mode, o_cpu_rst, o_in_ready},
            {59'b0, 1'b0, bad_ck, 1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        #1;
        chk("reset_outputs", {24'b0, w_outs}, {24'b0, 1'b1, 39'b0});
        repeat (3) @(negedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk); #1;
        chk("post_reset", {24'b0, w_outs}, {24'b0, 1'b1, 39'b0});
        pl = '{8'h11, 8'h22, 8'h33};
        run_frame(8'hA0, 8'h10, 0, 1'b0);
        pl = '{8'hAA, 8'hBB, 8'hCC};
        run_frame(8'hA1, 8'hFE, 0, 1'b0);
        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'(i));
        run_frame(8'hA0, 8'h00, 0, 1'b0);
        clear_obs();
        send(8'h5A, a);
        chk("bad_cmd", {59'b0, o_error, o_busy, o_service_mode, o_cpu_rst, o_in_ready}, {59'b0, 5'b10001});
        repeat (3) begin
            @(negedge i_clk); #1;
        end
        chk("bad_cmd_hold", {62'b0, o_error, o_busy}, {62'b0, 2'b10});
        pl = '{8'h01, 8'h02};
        run_frame(8'hA0, 8'h40, 0, 1'b0);
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        run_frame(8'hA1, 8'($urandom), 1, 1'b0);
        clear_obs();
        send(8'hA0, a);
        send(8'h10, a);
        send(8'h05, a);
        send(8'h77, a);
        send(8'h88, a);
        i_rst_n = 1'b0;
        #1;
        chk("midframe_reset", {24'b0, w_outs}, {24'b0, 1'b1, 39'b0});
        chk("midframe_writes", obs_wr.size(), 2);
        @(negedge i_clk); #1;
        i_rst_n = 1'b1;
        @(negedge i_clk); #1;
        pl = '{8'h5C, 8'hC5, 8'h3E};
        run_frame(8'hA0, 8'h10, 0, 1'b0);
        for (int f = 0; f < 6; f++) begin
            pl.delete();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) pl.push_back(8'($urandom));
            run_frame($urandom_range(0, 1) == 1 ? 8'hA1 : 8'hA0, 8'($urandom), 2, 1'b0);
        end
`ifdef LOADER_CHECKSUM_EN
        pl = '{8'h05};
        run_frame(8'hA0, 8'h00, 0, 1'b0);
        run_frame(8'hA0, 8'h00, 0, 1'b1);
        run_frame(8'hA0, 8'h00, 0, 1'b0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
